// File: rtl/sr_decode_stage_if.sv
// Fetch-to-execute handshake bundle for the decode stage.
// The master modport belongs to the surrounding pipeline and the slave modport belongs to the decode stage.
interface sr_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_op;
    logic [4:0]      out_rd;
    logic [2:0]      out_f3;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [6:0]      out_f7;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_imm_type;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_op, out_rd, out_f3, out_rs1,
               out_rs2, out_f7, out_imm, out_imm_type, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_op, out_rd, out_f3, out_rs1,
               out_rs2, out_f7, out_imm, out_imm_type, out_illegal
    );
endinterface

// File: rtl/sr_decode_stage.sv
// RV32I/RV64I decode stage: registers fetch beats (optional skid buffer) and
// decodes fields, immediate and illegal-opcode flag from the registered word.
module sr_decode_stage #(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    sr_decode_stage_if.slave bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    logic [31:0]     r_main_instr;
    logic [XLEN-1:0] r_main_pc;
    logic            r_main_vld;

    logic w_accept;
    logic w_emit;

    assign w_accept = bus.in_valid & bus.in_ready;
    assign w_emit   = r_main_vld & bus.out_ready;

    generate
        if (SKID) begin : g_skid
            logic [31:0]     r_skid_instr;
            logic [XLEN-1:0] r_skid_pc;
            logic            r_skid_vld;

            // in_ready is a pure flop output, so fetch never sees a path from out_ready.
            assign bus.in_ready = ~r_skid_vld;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_main_instr <= '0;
                    r_main_pc    <= '0;
                    r_main_vld   <= 1'b0;
                    r_skid_instr <= '0;
                    r_skid_pc    <= '0;
                    r_skid_vld   <= 1'b0;
                end else if (bus.flush) begin
                    r_main_vld <= 1'b0;
                    r_skid_vld <= 1'b0;
                end else if (w_emit || !r_main_vld) begin
                    if (r_skid_vld) begin
                        r_main_instr <= r_skid_instr;
                        r_main_pc    <= r_skid_pc;
                        r_main_vld   <= 1'b1;
                        r_skid_vld   <= 1'b0;
                    end else if (w_accept) begin
                        r_main_instr <= bus.in_instr;
                        r_main_pc    <= bus.in_pc;
                        r_main_vld   <= 1'b1;
                    end else begin
                        r_main_vld <= 1'b0;
                    end
                end else if (w_accept) begin
                    r_skid_instr <= bus.in_instr;
                    r_skid_pc    <= bus.in_pc;
                    r_skid_vld   <= 1'b1;
                end
            end
        end else begin : g_single
            assign bus.in_ready = ~r_main_vld | bus.out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_main_instr <= '0;
                    r_main_pc    <= '0;
                    r_main_vld   <= 1'b0;
                end else if (bus.flush) begin
                    r_main_vld <= 1'b0;
                end else if (w_emit || !r_main_vld) begin
                    if (w_accept) begin
                        r_main_instr <= bus.in_instr;
                        r_main_pc    <= bus.in_pc;
                    end
                    r_main_vld <= w_accept;
                end
            end
        end
    endgenerate

    logic [6:0]  w_op;
    logic [31:0] w_imm32;
    logic [2:0]  w_imm_type;
    logic        w_illegal;

    assign w_op = r_main_instr[6:0];

    // Immediates are built at 32 bits and sign-extended once below.
    always_comb begin
        w_imm32    = 32'd0;
        w_imm_type = IMM_NONE;
        w_illegal  = 1'b0;
        case (w_op)
            OP_LOAD, OP_OPIMM, OP_JALR, OP_SYSTEM: begin
                w_imm_type = IMM_I;
                w_imm32    = {{21{r_main_instr[31]}}, r_main_instr[30:20]};
            end
            OP_STORE: begin
                w_imm_type = IMM_S;
                w_imm32    = {{21{r_main_instr[31]}}, r_main_instr[30:25], r_main_instr[11:7]};
            end
            OP_BRANCH: begin
                w_imm_type = IMM_B;
                w_imm32    = {{20{r_main_instr[31]}}, r_main_instr[7], r_main_instr[30:25],
                              r_main_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                w_imm_type = IMM_U;
                w_imm32    = {r_main_instr[31:12], 12'b0};
            end
            OP_JAL: begin
                w_imm_type = IMM_J;
                w_imm32    = {{12{r_main_instr[31]}}, r_main_instr[19:12], r_main_instr[20],
                              r_main_instr[30:21], 1'b0};
            end
            OP_OP, OP_MISC: begin
                w_imm_type = IMM_NONE;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    generate
        if (XLEN == 64) begin : g_x64
            assign bus.out_imm = {{32{w_imm32[31]}}, w_imm32};
        end else begin : g_x32
            assign bus.out_imm = w_imm32;
        end
    endgenerate

    assign bus.out_valid    = r_main_vld;
    assign bus.out_pc       = r_main_pc;
    assign bus.out_op       = w_op;
    assign bus.out_rd       = r_main_instr[11:7];
    assign bus.out_f3       = r_main_instr[14:12];
    assign bus.out_rs1      = r_main_instr[19:15];
    assign bus.out_rs2      = r_main_instr[24:20];
    assign bus.out_f7       = r_main_instr[31:25];
    assign bus.out_imm_type = w_imm_type;
    assign bus.out_illegal  = w_illegal;
endmodule

// File: tb/tb_sr_decode_stage.sv
// Scoreboard bench for sr_decode_stage: DUT 0 is XLEN=32/SKID=1, DUT 1 is XLEN=64/SKID=0.
// Drivers push hand-computed expectations and a negedge monitor pops and compares them.
module tb_sr_decode_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sr_decode_stage_if #(.XLEN(32)) ifa ();
    sr_decode_stage_if #(.XLEN(64)) ifb ();

    sr_decode_stage #(.XLEN(32), .SKID(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    sr_decode_stage #(.XLEN(64), .SKID(1'b0)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
        int          acc;
        bit          lat;
    } exp_t;

    typedef struct {
        logic        vld, rdy, inr, fl;
        logic [63:0] pc, imm;
        logic [31:0] word;
        logic [2:0]  typ;
        logic        ill;
    } obs_t;

    // Hand-decoded vectors: instruction, 64-bit sign-extended immediate, type, illegal.
    logic [31:0] v_instr [14] = '{
        32'hFFF00093, 32'h00112623, 32'hFE000EE3, 32'h800000B7, 32'h0000006F,
        32'h0000000B, 32'h00000010, 32'h00001297, 32'h00412083, 32'h002081B3,
        32'h0000000F, 32'h00000073, 32'hFF5FF06F, 32'hFE112E23};
    logic [63:0] v_imm [14] = '{
        64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_000C, 64'hFFFF_FFFF_FFFF_FFFC,
        64'hFFFF_FFFF_8000_0000, 64'h0, 64'h0, 64'h0, 64'h0000_0000_0000_1000,
        64'h0000_0000_0000_0004, 64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF4,
        64'hFFFF_FFFF_FFFF_FFFC};
    logic [2:0] v_typ [14] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0, 3'd4, 3'd1, 3'd0,
                               3'd0, 3'd1, 3'd5, 3'd2};
    logic v_ill [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b0, 1'b0, 1'b0};

    exp_t qa[$];
    exp_t qb[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    obs_t prev [2];
    bit prev_st [2] = '{1'b0, 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic obs_t f_out(input int s);
        obs_t o;
        if (s == 0) begin
            o.vld = ifa.out_valid; o.rdy = ifa.out_ready; o.inr = ifa.in_ready; o.fl = ifa.flush;
            o.pc = {32'b0, ifa.out_pc}; o.imm = {32'b0, ifa.out_imm};
            o.word = {ifa.out_f7, ifa.out_rs2, ifa.out_rs1, ifa.out_f3, ifa.out_rd, ifa.out_op};
            o.typ = ifa.out_imm_type; o.ill = ifa.out_illegal;
        end else begin
            o.vld = ifb.out_valid; o.rdy = ifb.out_ready; o.inr = ifb.in_ready; o.fl = ifb.flush;
            o.pc = ifb.out_pc; o.imm = ifb.out_imm;
            o.word = {ifb.out_f7, ifb.out_rs2, ifb.out_rs1, ifb.out_f3, ifb.out_rd, ifb.out_op};
            o.typ = ifb.out_imm_type; o.ill = ifb.out_illegal;
        end
        return o;
    endfunction

    task automatic set_in(input int s, input logic v, input logic [31:0] ins, input logic [63:0] pc);
        if (s == 0) begin ifa.in_valid = v; ifa.in_instr = ins; ifa.in_pc = pc[31:0]; end
        else begin ifb.in_valid = v; ifb.in_instr = ins; ifb.in_pc = pc; end
    endtask

    task automatic set_rdy(input int s, input logic v);
        if (s == 0) ifa.out_ready = v; else ifb.out_ready = v;
    endtask

    task automatic set_flush(input int s, input logic v);
        if (s == 0) ifa.flush = v; else ifb.flush = v;
    endtask

    function automatic int qsize(input int s);
        return (s == 0) ? qa.size() : qb.size();
    endfunction

    function automatic exp_t qpop(input int s);
        return (s == 0) ? qa.pop_front() : qb.pop_front();
    endfunction

    task automatic mon_step(input int s);
        obs_t o;
        exp_t e;
        logic [63:0] m;
        o = f_out(s);
        m = (s == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        if (!rst_n || o.fl) begin
            prev_st[s] = 1'b0;
            return;
        end
        if (o.vld && o.rdy) begin
            if (qsize(s) == 0) begin
                n_vec++; n_err++;
                $display("FAIL dut%0d_unexpected_beat: got pc %0h, expected no output", s, o.pc);
            end else begin
                e = qpop(s);
                chk($sformatf("dut%0d_pc", s), o.pc, e.pc & m);
                chk($sformatf("dut%0d_fields", s), 64'(o.word), 64'(e.instr));
                chk($sformatf("dut%0d_imm", s), o.imm, e.imm & m);
                chk($sformatf("dut%0d_imm_type", s), 64'(o.typ), 64'(e.typ));
                chk($sformatf("dut%0d_illegal", s), 64'(o.ill), 64'(e.ill));
                if (e.lat) chk($sformatf("dut%0d_latency", s), 64'(cyc), 64'(e.acc + 1));
            end
        end
        if (o.vld && !o.rdy) begin
            if (prev_st[s]) begin
                chk($sformatf("dut%0d_stall_pc", s), o.pc, prev[s].pc);
                chk($sformatf("dut%0d_stall_fields", s), 64'(o.word), 64'(prev[s].word));
                chk($sformatf("dut%0d_stall_imm", s), o.imm, prev[s].imm);
            end
            prev[s] = o;
            prev_st[s] = 1'b1;
        end else begin
            prev_st[s] = 1'b0;
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            mon_step(0);
            mon_step(1);
        end
    end

    // Called and returns at posedge+1; in_ready is sampled at the negedge before the accepting edge.
    task automatic send(input int s, input int idx, input logic [63:0] pc, input bit lat);
        exp_t e;
        bit done = 1'b0;
        set_in(s, 1'b1, v_instr[idx], pc);
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (f_out(s).inr && !f_out(s).fl) begin
                e.instr = v_instr[idx]; e.pc = pc; e.imm = v_imm[idx];
                e.typ = v_typ[idx]; e.ill = v_ill[idx]; e.acc = cyc; e.lat = lat;
                if (s == 0) qa.push_back(e); else qb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        set_in(s, 1'b0, 32'h0, 64'h0);
        if (!done) chk($sformatf("dut%0d_send_timeout", s), 64'(done), 64'd1);
    endtask

    task automatic drain(input int s);
        for (int k = 0; k < 50 && qsize(s) != 0; k++) @(posedge clk);
        #1;
        chk($sformatf("dut%0d_drain", s), 64'(qsize(s)), 64'd0);
    endtask

    task automatic t_sweep(input int s, input logic [63:0] base);
        set_rdy(s, 1'b1);
        for (int k = 0; k < 14; k++) send(s, k, base + 64'(4 * k), 1'b1);
        drain(s);
    endtask

    task automatic t_backpressure(input int s, input logic [63:0] base);
        set_rdy(s, 1'b0);
        fork
            begin
                for (int k = 0; k < 4; k++) send(s, k + 7, base + 64'(4 * k), 1'b0);
            end
            begin
                @(posedge clk); #1;
                if (s == 0) begin
                    chk("dut0_in_ready_after_A", 64'(f_out(s).inr), 64'd1);
                    @(posedge clk); #1;
                    chk("dut0_in_ready_skid_full", 64'(f_out(s).inr), 64'd0);
                    @(posedge clk); #1;
                    set_rdy(s, 1'b1);
                end else begin
                    chk("dut1_in_ready_stalled", 64'(f_out(s).inr), 64'd0);
                    @(posedge clk); @(posedge clk); #1;
                    set_rdy(s, 1'b1);
                    #1;
                    chk("dut1_in_ready_comb", 64'(f_out(s).inr), 64'd1);
                end
            end
        join
        drain(s);
    endtask

    task automatic t_throughput(input int s, input logic [63:0] base);
        int c0;
        set_rdy(s, 1'b1);
        c0 = cyc;
        for (int k = 0; k < 16; k++) send(s, k % 14, base + 64'(4 * k), 1'b1);
        chk($sformatf("dut%0d_16_beats_cycles", s), 64'(cyc - c0), 64'd16);
        drain(s);
    endtask

    task automatic t_flush(input int s, input logic [63:0] base);
        set_rdy(s, 1'b0);
        if (s == 0) begin
            send(s, 0, base, 1'b0);
            send(s, 1, base + 64'd4, 1'b0);
        end
        set_in(s, 1'b1, v_instr[2], base + 64'd8);
        set_flush(s, 1'b1);
        @(negedge clk);
        if (s == 0) qa.delete(); else qb.delete();
        @(posedge clk); #1;
        set_flush(s, 1'b0);
        set_in(s, 1'b0, 32'h0, 64'h0);
        chk($sformatf("dut%0d_flush_out_valid", s), 64'(f_out(s).vld), 64'd0);
        chk($sformatf("dut%0d_flush_in_ready", s), 64'(f_out(s).inr), 64'd1);
        set_rdy(s, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        send(s, 3, base + 64'h100, 1'b1);
        drain(s);
    endtask

    task automatic t_reset(input int s, input logic [63:0] base);
        set_rdy(s, 1'b0);
        send(s, 4, base, 1'b0);
        chk($sformatf("dut%0d_pre_reset_valid", s), 64'(f_out(s).vld), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk($sformatf("dut%0d_async_reset_valid", s), 64'(f_out(s).vld), 64'd0);
        qa.delete();
        qb.delete();
        #2 rst_n = 1'b1;
        #1;
        chk($sformatf("dut%0d_reset_in_ready", s), 64'(f_out(s).inr), 64'd1);
        @(posedge clk); #1;
        set_rdy(s, 1'b1);
        send(s, 12, base + 64'h40, 1'b1);
        drain(s);
    endtask

    task automatic reset_state(input int s);
        obs_t o;
        o = f_out(s);
        chk($sformatf("dut%0d_rst_out_valid", s), 64'(o.vld), 64'd0);
        chk($sformatf("dut%0d_rst_in_ready", s), 64'(o.inr), 64'd1);
        chk($sformatf("dut%0d_rst_pc", s), o.pc, 64'd0);
        chk($sformatf("dut%0d_rst_fields", s), 64'(o.word), 64'd0);
        chk($sformatf("dut%0d_rst_imm", s), o.imm, 64'd0);
        chk($sformatf("dut%0d_rst_imm_type", s), 64'(o.typ), 64'd0);
        chk($sformatf("dut%0d_rst_illegal", s), 64'(o.ill), 64'd1);
    endtask

    initial begin : stimulus
        set_in(0, 1'b0, 32'h0, 64'h0);
        set_in(1, 1'b0, 32'h0, 64'h0);
        set_flush(0, 1'b0);
        set_flush(1, 1'b0);
        set_rdy(0, 1'b1);
        set_rdy(1, 1'b1);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        reset_state(0);
        reset_state(1);

        t_sweep(0, 64'h0000_0000_8000_0000);
        t_backpressure(0, 64'h0000_0000_0000_2000);
        t_throughput(0, 64'h0000_0000_0000_3000);
        t_flush(0, 64'h0000_0000_0000_4000);
        t_reset(0, 64'h0000_0000_0000_5000);

        t_sweep(1, 64'hFFFF_0000_0000_1000);
        t_backpressure(1, 64'h1234_5678_0000_2000);
        t_throughput(1, 64'h8000_0001_0000_3000);
        t_flush(1, 64'h0000_0002_0000_4000);
        t_reset(1, 64'h0000_0003_0000_5000);

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sr_decode_stage.md
Name: sr_decode_stage

Overview:
Registered, parametrised RISC-V RV32I/RV64I decode stage. It sits between fetch and execute in the pipelined core and exchanges data with both through valid/ready handshakes. It splits instruction fields, selects and sign-extends the opcode-appropriate immediate to XLEN, and flags illegal opcodes. An optional skid buffer sustains one instruction per cycle under backpressure.

Parameters:
XLEN, 32, datapath width for pc and immediate; legal values 32 or 64.
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush (branch redirect/trap)
in_valid  input  1  fetch presents an instruction
in_ready  output  1  stage can accept this cycle
in_instr  input  32  raw instruction word
in_pc  input  XLEN  pc of in_instr
out_valid  output  1  decoded instruction available
out_ready  input  1  execute accepts this cycle
out_pc  output  XLEN  pc, passed through
out_op  output  7  instr[6:0]
out_rd  output  5  instr[11:7]
out_f3  output  3  instr[14:12]
out_rs1  output  5  instr[19:15]
out_rs2  output  5  instr[24:20]
out_f7  output  7  instr[31:25]
out_imm  output  XLEN  selected immediate, sign-extended
out_imm_type  output  3  0 none, 1 I, 2 S, 3 B, 4 U, 5 J
out_illegal  output  1  unsupported opcode or instr[1:0] != 2'b11

Behaviour:
- Transfer rule: a beat moves when valid && ready on the same rising edge. Only in_instr and in_pc are registered; decoding is done on the registered word(s).
- Immediate selection by opcode:
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011 -> I.
  - STORE 0100011 -> S. BRANCH 1100011 -> B. LUI 0110111, AUIPC 0010111 -> U. JAL 1101111 -> J.
  - OP 0110011, MISC-MEM 0001111 -> none, imm = 0.
  - Any other opcode -> illegal = 1, type = none, imm = 0.
- Bit layouts: I {sx, i[30:20]}; S {sx, i[30:25], i[11:7]}; B {sx, i[7], i[30:25], i[11:8], 0}; U {sx, i[31:12], 12'b0}; J {sx, i[19:12], i[20], i[30:21], 0}. sx replicates instr[31] up to XLEN. For XLEN=64, U bits [63:32] also replicate instr[31].
- Latency: 1 cycle. A beat accepted at edge N is visible on out_* after edge N.
- Throughput: 1 beat per cycle when out_ready is held high.
- Stall: while out_valid && !out_ready, every out_* is held stable.
- SKID=1:
  - Main and skid registers, each with its own valid bit. in_ready = !skid_valid, taken directly from a flop.
  - Accept while main is stalled -> beat goes to skid; in_ready drops on the next cycle.
  - On out_ready: skid content moves to main, or the new input moves to main if skid is empty.
  - Ordering is strictly FIFO; no beat is dropped or duplicated.
- SKID=0: single main register. in_ready = !out_valid || out_ready (combinational path).
- Simultaneous accept and emit: main is replaced by the next beat (skid first if occupied) with no bubble.
- Flush: on the edge where flush = 1, both valid bits clear. An input handshaking in that same cycle is discarded. out_valid = 0 and in_ready = 1 after that edge. Flush takes priority over all transfers.
- Reset, asynchronous on rst_n low:
  - Valid bits and stored data = 0, so out_valid = 0 and out_* = 0; out_illegal = 1 because opcode 0 is illegal, but it is qualified by out_valid.
  - in_ready = 1 once reset is released (both variants).
  - Reset asserted mid-transfer discards all in-flight beats.
- No X propagation: out_* with out_valid = 0 reflect the stored (possibly stale) word and are not meaningful.

Test Plan:
- Field/imm sweep, out_ready = 1:
  - 0xFFF00093 (addi x1,x0,-1) -> type 1, imm all-ones, rd 1.
  - 0x00112623 (sw x1,12(x2)) -> type 2, imm 12.
  - 0xFE000EE3 (beq, offset -4) -> type 3, imm -4.
  - 0x800000B7 (lui) -> type 4, imm 0x80000000 at XLEN=32, 0xFFFFFFFF80000000 at XLEN=64.
  - 0x0000006F (jal x0, 0) -> type 5, imm 0.
- Illegal: 0x0000000B and 0x00000013 with bits[1:0] forced to 00 -> out_illegal = 1, imm 0, still handed off normally.
- Backpressure, SKID=1: stream A,B,C,D back-to-back with out_ready low for 3 cycles mid-stream.
  - in_ready drops one cycle after B is captured in skid.
  - Output order A,B,C,D with no duplicates; out_* stable during the stall.
- Full throughput: 16 consecutive beats, both ready signals high -> 16 outputs in 16 consecutive cycles, each 1 cycle after input.
- Flush: skid and main both full, flush pulsed with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, flushed beats never appear.
- Async reset: drop rst_n between clock edges while out_valid = 1 -> out_valid falls immediately. After release, the first accepted beat appears 1 cycle later. Run with SKID=0 and SKID=1.
